ts_packet_buffer: RTL

- Per-channel TS packet buffer sitting directly upstream of the source switch; one instance per tuner channel (4 total).
- Takes a byte stream from the channel's input stage (already in the SYS_CLK domain), aligns it on sync, discards malformed packets and stores complete packets in slot memory.
- Raises GOT_FULL_PACKET while at least one complete packet is stored, and serves bytes show-ahead on RD_REQ for the switch's 188-byte read burst.

---
 rtl/ts_packet_buffer_if.sv | 27 ++
 rtl/ts_packet_buffer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ts_packet_buffer_if.sv
// Byte-stream input, read burst and status signals of one TS packet buffer channel.
// slave = buffer side, master = input stage / switch side.
interface ts_packet_buffer_if #(
    parameter int SLOTS_LOG2 = 2
);
    logic [7:0]          IN_DATA;
    logic                IN_VALID;
    logic                IN_PSYNC;
    logic                CNT_CLR;
    logic                RD_REQ;
    logic [7:0]          DATA_OUT;
    logic                GOT_FULL_PACKET;
    logic [SLOTS_LOG2:0] PKT_COUNT;
    logic [7:0]          SYNC_ERR_CNT;
    logic [7:0]          OVF_CNT;
    logic                UNDERRUN;

    modport slave (
        input  IN_DATA, IN_VALID, IN_PSYNC, CNT_CLR, RD_REQ,
        output DATA_OUT, GOT_FULL_PACKET, PKT_COUNT, SYNC_ERR_CNT, OVF_CNT, UNDERRUN
    );

    modport master (
        output IN_DATA, IN_VALID, IN_PSYNC, CNT_CLR, RD_REQ,
        input  DATA_OUT, GOT_FULL_PACKET, PKT_COUNT, SYNC_ERR_CNT, OVF_CNT, UNDERRUN
    );
endinterface

// File: rtl/ts_packet_buffer.sv
// Sync-aligned TS packet buffer: stores complete packets in slots, serves bytes show-ahead.
// Latency: packet readable the edge after its last byte; GOT_FULL_PACKET lags PKT_COUNT by one cycle.
// No backpressure: packets arriving with no free slot are dropped and counted.
module ts_packet_buffer #(
    parameter int         PKT_LEN    = 188,
    parameter int         SLOTS_LOG2 = 2,
    parameter logic [7:0] SYNC_BYTE  = 8'h47,
    parameter bit         CHECK_SYNC = 1'b1
) (
    input  logic                SYS_CLK,
    input  logic                RST,
    ts_packet_buffer_if.slave   bus
);
    localparam int                  AW       = SLOTS_LOG2 + 8;
    localparam logic [7:0]          LAST_OFF = 8'(PKT_LEN - 1);
    localparam logic [SLOTS_LOG2:0] N_SLOTS  = (SLOTS_LOG2+1)'(1 << SLOTS_LOG2);

    typedef enum logic [1:0] {HUNT, FILL, AFTER, DROP} wr_state_t;

    wr_state_t             state;
    logic [SLOTS_LOG2-1:0] wr_slot, rd_slot;
    logic [7:0]            wr_off, rd_off;
    logic [SLOTS_LOG2:0]   pkt_count;
    logic [7:0]            sync_err_cnt, ovf_cnt;
    logic                  got_full, underrun;
    logic [7:0]            mem [0:(1<<AW)-1];

    logic       start_eval, sync_ok, has_space;
    logic       start_accept, start_ovf, start_bad;
    logic       fill_wr, commit, short_err, long_err;
    logic       rd_fire, free_slot;
    logic [1:0] sync_inc;

    function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // A valid PSYNC byte is always treated as a packet start, whatever state we are in.
    always_comb begin
        start_eval   = bus.IN_VALID && bus.IN_PSYNC;
        sync_ok      = !CHECK_SYNC || (bus.IN_DATA == SYNC_BYTE);
        has_space    = pkt_count < N_SLOTS;
        start_accept = start_eval && sync_ok && has_space;
        start_ovf    = start_eval && sync_ok && !has_space;
        start_bad    = start_eval && !sync_ok;
        fill_wr      = (state == FILL) && bus.IN_VALID && !bus.IN_PSYNC;
        commit       = fill_wr && (wr_off == LAST_OFF);
        short_err    = (state == FILL) && start_eval;
        long_err     = (state == AFTER) && bus.IN_VALID && !bus.IN_PSYNC;
        sync_inc     = {1'b0, short_err || long_err} + {1'b0, start_bad};
        rd_fire      = bus.RD_REQ && (pkt_count != '0);
        free_slot    = rd_fire && (rd_off == LAST_OFF);
    end

    always_ff @(posedge SYS_CLK) begin
        if (start_accept)
            mem[{wr_slot, 8'd0}] <= bus.IN_DATA;
        else if (fill_wr)
            mem[{wr_slot, wr_off}] <= bus.IN_DATA;
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state   <= HUNT;
            wr_slot <= '0;
            wr_off  <= '0;
        end else if (start_accept) begin
            state  <= FILL;
            wr_off <= 8'd1;
        end else if (start_ovf) begin
            state <= DROP;
        end else if (start_bad) begin
            state <= HUNT;
        end else if (commit) begin
            state   <= AFTER;
            wr_slot <= wr_slot + 1'b1;
            wr_off  <= '0;
        end else if (fill_wr) begin
            wr_off <= wr_off + 8'd1;
        end else if (long_err) begin
            state <= HUNT;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            rd_slot   <= '0;
            rd_off    <= '0;
            pkt_count <= '0;
            got_full  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (rd_fire) begin
                if (free_slot) begin
                    rd_off  <= '0;
                    rd_slot <= rd_slot + 1'b1;
                end else begin
                    rd_off <= rd_off + 8'd1;
                end
            end
            if (commit && !free_slot)
                pkt_count <= pkt_count + 1'b1;
            else if (free_slot && !commit)
                pkt_count <= pkt_count - 1'b1;
            got_full <= (pkt_count != '0);
            underrun <= bus.RD_REQ && (pkt_count == '0);
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            sync_err_cnt <= '0;
            ovf_cnt      <= '0;
        end else if (bus.CNT_CLR) begin
            sync_err_cnt <= '0;
            ovf_cnt      <= '0;
        end else begin
            sync_err_cnt <= sat_add(sync_err_cnt, sync_inc);
            ovf_cnt      <= sat_add(ovf_cnt, {1'b0, start_ovf});
        end
    end

    assign bus.DATA_OUT        = mem[{rd_slot, rd_off}];
    assign bus.GOT_FULL_PACKET = got_full;
    assign bus.PKT_COUNT       = pkt_count;
    assign bus.SYNC_ERR_CNT    = sync_err_cnt;
    assign bus.OVF_CNT         = ovf_cnt;
    assign bus.UNDERRUN        = underrun;
endmodule
